// File: rtl/regfile_pkg.sv
// Shared constants and state type for the 8 x 32-bit register bank and its read port.
package regfile_pkg;

  localparam int NUM_REGS = 8;
  localparam int ADDR_W   = 3;
  localparam int DATA_W   = 32;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } rd_state_e;

endpackage

// File: rtl/regfile_rd_mux.sv
// Combinational 8:1 select of the bank outputs by register index.
// READ_BYPASS_EN: a write landing on the selected register on the same edge overrides the bank value.
module regfile_rd_mux #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rd_in0,
  input  logic [DATA_W-1:0] rd_in1,
  input  logic [DATA_W-1:0] rd_in2,
  input  logic [DATA_W-1:0] rd_in3,
  input  logic [DATA_W-1:0] rd_in4,
  input  logic [DATA_W-1:0] rd_in5,
  input  logic [DATA_W-1:0] rd_in6,
  input  logic [DATA_W-1:0] rd_in7,
  input  logic [2:0]        sel_i,
  input  logic [7:0]        wr_en_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic [DATA_W-1:0] data_o
);
  import regfile_pkg::*;

  logic [DATA_W-1:0] bank [NUM_REGS];

  assign bank[0] = rd_in0;
  assign bank[1] = rd_in1;
  assign bank[2] = rd_in2;
  assign bank[3] = rd_in3;
  assign bank[4] = rd_in4;
  assign bank[5] = rd_in5;
  assign bank[6] = rd_in6;
  assign bank[7] = rd_in7;

`ifdef READ_BYPASS_EN
  always_comb begin
    data_o = bank[sel_i];
    // Return the value the bank will hold after this edge.
    if (wr_en_i[sel_i]) begin
      data_o = wr_data_i;
    end
  end
`else
  logic unused_bypass_nc;
  assign unused_bypass_nc = ^{wr_en_i, wr_data_i};
  assign data_o = bank[sel_i];
`endif

endmodule

// File: rtl/register32_8_reader.sv
// Burst read streaming port for the 8 x 32-bit register bank (valid/ready, full backpressure).
// READ_BYPASS_EN selects write-through of same-edge bank writes into loaded beats.
//
// state  | meaning
// IDLE   | no burst; req_ready high, waiting for a request
// STREAM | out_data holds a beat; advances on out_ready
module register32_8_reader #(
  parameter int DATA_W = 32,
  parameter int LEN_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] rd_in0,
  input  logic [DATA_W-1:0] rd_in1,
  input  logic [DATA_W-1:0] rd_in2,
  input  logic [DATA_W-1:0] rd_in3,
  input  logic [DATA_W-1:0] rd_in4,
  input  logic [DATA_W-1:0] rd_in5,
  input  logic [DATA_W-1:0] rd_in6,
  input  logic [DATA_W-1:0] rd_in7,
  input  logic [7:0]        wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_addr,
  input  logic [LEN_W-1:0]  req_len,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [2:0]        out_addr,
  output logic              out_last,
  output logic              busy
);
  import regfile_pkg::*;

  rd_state_e         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0] oaddr_q, oaddr_d;
  logic              last_q, last_d;

  logic [ADDR_W-1:0] sel;
  logic [DATA_W-1:0] sel_data;

  // The first beat comes straight from the request; later beats from the walking address.
  assign sel = (state_q == IDLE) ? req_addr : addr_q;

  regfile_rd_mux #(.DATA_W(DATA_W)) u_rd_mux (
    .rd_in0    (rd_in0),
    .rd_in1    (rd_in1),
    .rd_in2    (rd_in2),
    .rd_in3    (rd_in3),
    .rd_in4    (rd_in4),
    .rd_in5    (rd_in5),
    .rd_in6    (rd_in6),
    .rd_in7    (rd_in7),
    .sel_i     (sel),
    .wr_en_i   (wr_en),
    .wr_data_i (wr_data),
    .data_o    (sel_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      oaddr_q <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      oaddr_q <= oaddr_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    oaddr_d   = oaddr_q;
    last_d    = last_q;
    req_ready = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        // Zero-length requests are consumed without producing a beat.
        if (req_valid && (req_len != '0)) begin
          data_d  = sel_data;
          oaddr_d = req_addr;
          last_d  = (req_len == LEN_W'(1));
          addr_d  = req_addr + 3'd1;
          cnt_d   = req_len - LEN_W'(1);
          state_d = STREAM;
        end
      end
      STREAM: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (last_q) begin
            last_d  = 1'b0;
            state_d = IDLE;
          end else begin
            data_d  = sel_data;
            oaddr_d = addr_q;
            last_d  = (cnt_q == LEN_W'(1));
            addr_d  = addr_q + 3'd1;
            cnt_d   = cnt_q - LEN_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign out_data = data_q;
  assign out_addr = oaddr_q;
  assign out_last = last_q;
  assign busy     = out_valid;

endmodule

// File: tb/tb_register32_8_reader.sv
// Directed self-checking bench for register32_8_reader; the bench owns the register bank model.
module tb_register32_8_reader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] bank [8];
  logic [7:0]  wr_en = '0;
  logic [31:0] wr_data = '0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_addr = '0;
  logic [3:0]  req_len = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [2:0]  out_addr;
  logic        out_last;
  logic        busy;

  int checks = 0;
  int failures = 0;

`ifdef READ_BYPASS_EN
  localparam logic [31:0] BYP_EXP = 32'hDEADBEEF;
`else
  localparam logic [31:0] BYP_EXP = 32'h1000_0003;
`endif

  always #5 clk = ~clk;

  always @(posedge clk) begin
    for (int k = 0; k < 8; k++) begin
      if (wr_en[k]) bank[k] <= wr_data;
    end
  end

  register32_8_reader dut (
    .clk       (clk),
    .reset     (reset),
    .rd_in0    (bank[0]),
    .rd_in1    (bank[1]),
    .rd_in2    (bank[2]),
    .rd_in3    (bank[3]),
    .rd_in4    (bank[4]),
    .rd_in5    (bank[5]),
    .rd_in6    (bank[6]),
    .rd_in7    (bank[7]),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_len   (req_len),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_addr  (out_addr),
    .out_last  (out_last),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, ".ready"}, {31'd0, req_ready}, 32'd1);
  endtask

  // Issue a request and drain it with out_ready held high; bank assumed at preload values.
  task automatic burst(input logic [2:0] a, input logic [3:0] len);
    logic [2:0] ea;
    @(negedge clk);
    req_valid = 1'b1; req_addr = a; req_len = len; out_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    ea = a;
    for (int i = 0; i < int'(len); i++) begin
      chk($sformatf("b%0d_%0d.valid", a, i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("b%0d_%0d.ready", a, i), {31'd0, req_ready}, 32'd0);
      chk($sformatf("b%0d_%0d.addr", a, i), {29'd0, out_addr}, {29'd0, ea});
      chk($sformatf("b%0d_%0d.data", a, i), out_data, 32'h1000_0000 + {29'd0, ea});
      chk($sformatf("b%0d_%0d.last", a, i), {31'd0, out_last}, (i == int'(len) - 1) ? 32'd1 : 32'd0);
      ea = ea + 3'd1;
      @(negedge clk);
    end
    chk_idle($sformatf("b%0d_end", a));
  endtask

  task automatic bank_write(input int k, input logic [31:0] v);
    @(negedge clk);
    wr_en = 8'(1 << k); wr_data = v;
    @(negedge clk);
    wr_en = '0;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) bank[i] = 32'h1000_0000 + i;

    // Reset state
    #12;
    chk("rst.ready", {31'd0, req_ready}, 32'd1);
    chk("rst.valid", {31'd0, out_valid}, 32'd0);
    chk("rst.data", out_data, 32'd0);
    chk("rst.addr", {29'd0, out_addr}, 32'd0);
    chk("rst.last", {31'd0, out_last}, 32'd0);
    chk("rst.busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Basic, wrap and long wrap bursts
    burst(3'd2, 4'd3);
    burst(3'd6, 4'd4);
    burst(3'd0, 4'd10);

    // Backpressure on beat 2 with a write to the held register
    @(negedge clk);
    req_valid = 1'b1; req_addr = 3'd0; req_len = 4'd4; out_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    chk("bp.b1.data", out_data, 32'h1000_0000);
    @(negedge clk);
    out_ready = 1'b0;
    wr_en = 8'h02; wr_data = 32'hCAFE0001;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("bp.hold%0d.data", i), out_data, 32'h1000_0001);
      chk($sformatf("bp.hold%0d.addr", i), {29'd0, out_addr}, 32'd1);
      chk($sformatf("bp.hold%0d.valid", i), {31'd0, out_valid}, 32'd1);
      @(negedge clk);
      wr_en = '0;
    end
    out_ready = 1'b1;
    chk("bp.b2.data", out_data, 32'h1000_0001);
    @(negedge clk);
    chk("bp.b3.data", out_data, 32'h1000_0002);
    chk("bp.b3.addr", {29'd0, out_addr}, 32'd2);
    @(negedge clk);
    chk("bp.b4.data", out_data, 32'h1000_0003);
    chk("bp.b4.last", {31'd0, out_last}, 32'd1);
    @(negedge clk);
    chk_idle("bp.end");
    bank_write(1, 32'h1000_0001);

    // Bypass on the first beat (loaded from the request)
    @(negedge clk);
    req_valid = 1'b1; req_addr = 3'd3; req_len = 4'd1;
    wr_en = 8'h08; wr_data = 32'hDEADBEEF;
    @(negedge clk);
    req_valid = 1'b0; wr_en = '0;
    chk("byp0.data", out_data, BYP_EXP);
    chk("byp0.last", {31'd0, out_last}, 32'd1);
    @(negedge clk);
    chk_idle("byp0.end");
    bank_write(3, 32'h1000_0003);

    // Bypass on a streamed beat
    @(negedge clk);
    req_valid = 1'b1; req_addr = 3'd2; req_len = 4'd2;
    @(negedge clk);
    req_valid = 1'b0;
    chk("byp1.b1.data", out_data, 32'h1000_0002);
    wr_en = 8'h08; wr_data = 32'hDEADBEEF;
    @(negedge clk);
    wr_en = '0;
    chk("byp1.b2.data", out_data, BYP_EXP);
    chk("byp1.b2.addr", {29'd0, out_addr}, 32'd3);
    @(negedge clk);
    chk_idle("byp1.end");
    bank_write(3, 32'h1000_0003);

    // Zero length request
    @(negedge clk);
    req_valid = 1'b1; req_addr = 3'd5; req_len = 4'd0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      req_valid = 1'b0;
      chk_idle($sformatf("zl%0d", i));
    end

    // Asynchronous reset mid-burst
    @(negedge clk);
    req_valid = 1'b1; req_addr = 3'd0; req_len = 4'd5;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("ar.pre.valid", {31'd0, out_valid}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("ar.valid", {31'd0, out_valid}, 32'd0);
    chk("ar.busy", {31'd0, busy}, 32'd0);
    chk("ar.data", out_data, 32'd0);
    chk("ar.addr", {29'd0, out_addr}, 32'd0);
    chk("ar.ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_idle($sformatf("ar.post%0d", i));
    end

    // Stream still works after the abort
    burst(3'd7, 4'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
